debounce_scan_scheduler: RTL

Time-multiplexed debounce controller for N asynchronous discrete inputs (limit switches, fault lines).
- One shared compare/count datapath is scheduled round-robin across channels on a prescaled scan tick.
- Each channel has a run-time threshold of consecutive samples.
- Debounced level changes are queued as pending events and presented one at a time on a valid/ready interface to the actuator control logic.

---
 rtl/debounce_scan_pkg.sv | 17 +
 rtl/debounce_scan_scheduler_arbiter.sv | 60 ++++++
 rtl/debounce_scan_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/debounce_scan_pkg.sv
// Shared types and helpers for the debounce scan scheduler.
// Scan FSM states, prescale floor and id width helper.
package debounce_scan_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SAMPLE,
      UPDATE
   } scan_state_t;

   localparam int MIN_PRESCALE = 3;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/debounce_scan_scheduler_arbiter.sv
// Round-robin presenter for pending debounce events.
// Grants one channel at a time and holds id/level until accepted.
module rr_event_arbiter
   import debounce_scan_pkg::*;
#(
   parameter int N    = 4,
   parameter int ID_W = id_width(N)
) (
   input  logic            clk_i,
   input  logic            nReset_i,
   input  logic [N-1:0]    i_pending,
   input  logic [N-1:0]    i_level,
   input  logic            i_ready,
   output logic            o_valid,
   output logic [ID_W-1:0] o_id,
   output logic            o_level,
   output logic [N-1:0]    o_clr
);

   logic            r_valid;
   logic [ID_W-1:0] r_id;
   logic            r_level;
   logic [ID_W-1:0] r_last;
   logic            w_found;
   logic [ID_W-1:0] w_grant;

   // Search starts one past the last grant and wraps.
   always_comb begin
      w_found = 1'b0;
      w_grant = '0;
      for (int k = 1; k <= N; k++) begin
         if (!w_found && i_pending[(int'(r_last) + k) % N]) begin
            w_found = 1'b1;
            w_grant = ID_W'((int'(r_last) + k) % N);
         end
      end
   end

   always_ff @(posedge clk_i or negedge nReset_i) begin
      if (!nReset_i) begin
         r_valid <= 1'b0;
         r_id    <= '0;
         r_level <= 1'b1;
         r_last  <= ID_W'(N - 1);
      end else if (r_valid) begin
         if (i_ready) r_valid <= 1'b0;
      end else if (w_found) begin
         r_valid <= 1'b1;
         r_id    <= w_grant;
         r_level <= i_level[w_grant];
         r_last  <= w_grant;
      end
   end

   assign o_valid = r_valid;
   assign o_id    = r_id;
   assign o_level = r_level;
   assign o_clr   = (r_valid && i_ready) ? (N'(1) << r_id) : '0;

endmodule

// File: rtl/debounce_scan_scheduler.sv
// Time-multiplexed debouncer: one shared counter datapath scanned
// round-robin on a prescaled tick, with queued level-change events.
module debounce_scan_scheduler
   import debounce_scan_pkg::*;
#(
   parameter  int NUMBER_SIGNALS  = 4,
   parameter  int CLOCK_PERIOD_NS = 20,
   parameter  int SCAN_PERIOD_NS  = 125_000,
   parameter  int CNT_W           = 4,
   localparam int ID_W            = id_width(NUMBER_SIGNALS)
) (
   input  logic                      clk_i,
   input  logic                      nReset_i,
   input  logic                      enable_i,
   input  logic [CNT_W-1:0]          threshold_i,
   input  logic [NUMBER_SIGNALS-1:0] signals_i,
   output logic [NUMBER_SIGNALS-1:0] signals_o,
   output logic                      event_valid_o,
   input  logic                      event_ready_i,
   output logic [ID_W-1:0]           event_id_o,
   output logic                      event_level_o,
   output logic                      overrun_o
);

   localparam int N        = NUMBER_SIGNALS;
   localparam int RATIO    = SCAN_PERIOD_NS / CLOCK_PERIOD_NS;
   localparam int PRESCALE = (RATIO > MIN_PRESCALE) ? RATIO : MIN_PRESCALE;
   localparam int TICK_W   = $clog2(PRESCALE);

   logic [N-1:0]      r_meta;
   logic [N-1:0]      r_sync;
   logic [TICK_W-1:0] r_tick;
   scan_state_t       r_state;
   logic [ID_W-1:0]   r_idx;
   logic              r_samp;
   logic [CNT_W-1:0]  r_cnt_s;
   logic [CNT_W-1:0]  r_cnt [N];
   logic [N-1:0]      r_level;
   logic [N-1:0]      r_pending;
   logic              r_overrun;

   logic              w_tick;
   logic [CNT_W:0]    w_thr_eff;
   logic              w_differ;
   logic              w_toggle;
   logic              w_presented;
   logic [N-1:0]      w_lvl_nxt;
   logic [N-1:0]      w_set;
   logic [N-1:0]      w_clr;

   always_ff @(posedge clk_i or negedge nReset_i) begin
      if (!nReset_i) begin
         r_meta <= '1;
         r_sync <= '1;
      end else begin
         r_meta <= signals_i;
         r_sync <= r_meta;
      end
   end

   assign w_tick = enable_i && (r_tick == TICK_W'(PRESCALE - 1));

   always_ff @(posedge clk_i or negedge nReset_i) begin
      if (!nReset_i)     r_tick <= '0;
      else if (enable_i) r_tick <= w_tick ? '0 : r_tick + 1'b1;
   end

   // Compare in CNT_W+1 bits so a full counter never wraps.
   assign w_thr_eff   = (threshold_i == '0) ? (CNT_W+1)'(1)
                                            : {1'b0, threshold_i};
   assign w_differ    = r_samp != r_level[r_idx];
   assign w_toggle    = (r_state == UPDATE) && w_differ &&
                        (({1'b0, r_cnt_s} + 1'b1) >= w_thr_eff);
   assign w_presented = event_valid_o && (event_id_o == r_idx);
   assign w_set       = w_toggle ? (N'(1) << r_idx) : '0;

   always_comb begin
      w_lvl_nxt = r_level;
      if (w_toggle) w_lvl_nxt[r_idx] = ~r_level[r_idx];
   end

   always_ff @(posedge clk_i or negedge nReset_i) begin
      if (!nReset_i) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_samp    <= 1'b1;
         r_cnt_s   <= '0;
         r_cnt     <= '{default: '0};
         r_level   <= '1;
         r_pending <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         r_pending <= (r_pending & ~w_clr) | w_set;
         unique case (r_state)
            IDLE: if (w_tick) r_state <= SAMPLE;
            SAMPLE: begin
               r_samp  <= r_sync[r_idx];
               r_cnt_s <= r_cnt[r_idx];
               r_state <= UPDATE;
            end
            UPDATE: begin
               if (!w_differ || w_toggle) r_cnt[r_idx] <= '0;
               else                       r_cnt[r_idx] <= r_cnt_s + 1'b1;
               r_level   <= w_lvl_nxt;
               r_overrun <= w_toggle && r_pending[r_idx] && !w_presented;
               r_idx     <= (r_idx == ID_W'(N - 1)) ? '0 : r_idx + 1'b1;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   rr_event_arbiter #(
      .N    (N),
      .ID_W (ID_W)
   ) u_arb (
      .clk_i     (clk_i),
      .nReset_i  (nReset_i),
      .i_pending (r_pending),
      .i_level   (w_lvl_nxt),
      .i_ready   (event_ready_i),
      .o_valid   (event_valid_o),
      .o_id      (event_id_o),
      .o_level   (event_level_o),
      .o_clr     (w_clr)
   );

   assign signals_o = r_level;
   assign overrun_o = r_overrun;

endmodule
